// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared constants and queue entry type for the fetch front end
package cpu_fetch_pkg;

  // Instruction word presented to decode when nothing valid is at the head
  localparam logic [31:0] NOP_INSN = 32'h0;

  // PC loaded on reset unless the instance overrides it
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

  // One buffered fetch: the instruction and the address of the following one
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_next;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry circular prefetch FIFO with flush
module fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  fetch_entry_t  wr_data,
  input  logic          rd_en,
  output fetch_entry_t  rd_data,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          do_wr;
  logic          do_rd;

  // A full queue never takes a write, even if the head leaves this cycle;
  // flush overrides both directions.
  assign do_wr = wr_en && !flush && (count != FULL_CNT);
  assign do_rd = rd_en && !flush && (count != '0);

  assign rd_data = mem[head];

  // Entry storage needs no reset: count gates visibility of every slot
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[tail] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping, cleared by reset or flush
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        tail <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
      end
      if (do_rd) begin
        head <= (head == LAST_PTR) ? '0 : head + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - PC, imem request tracking and prefetch queue for the fetch stage
module fetch_prefetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        decode_ready,
  output logic        insn_valid,
  output logic [31:0] insn_out,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          pend_valid;
  logic [31:0]   pend_pc;
  logic [CW-1:0] count;
  logic [CW:0]   committed;
  logic          issue;
  logic          enq;
  logic          deq;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;

  // Only issue when the queue has room for this request plus the one in flight
  assign committed = {1'b0, count} + (CW + 1)'(pend_valid);
  assign issue     = !redirect_valid && (committed < DEPTH_W);

  // A response lands only if its request was issued and no redirect kills it
  assign enq      = pend_valid && !redirect_valid;
  assign wr_entry = '{insn: q_imem, pc_next: pend_pc + 32'd1};

  assign insn_valid = (count != '0);
  assign deq        = insn_valid && decode_ready;

  assign address_imem = fetch_pc;
  assign insn_out     = insn_valid ? head_entry.insn : NOP_INSN;
  assign pc_out       = insn_valid ? head_entry.pc_next : 32'h0;

  // PC advance and in-flight request tracking; redirect wins over issue
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc;
      pend_valid <= 1'b0;
    end else if (issue) begin
      fetch_pc   <= fetch_pc + 32'd1;
      pend_valid <= 1'b1;
      pend_pc    <= fetch_pc;
    end else begin
      pend_valid <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .flush   (redirect_valid),
    .wr_en   (enq),
    .wr_data (wr_entry),
    .rd_en   (deq),
    .rd_data (head_entry),
    .count   (count)
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        decode_ready;
  logic        insn_valid;
  logic [31:0] insn_out;
  logic [31:0] pc_out;

  logic [31:0] address_imem_w;
  logic [31:0] q_imem_w;
  logic        redirect_valid_w;
  logic [31:0] redirect_pc_w;
  logic        decode_ready_w;
  logic        insn_valid_w;
  logic [31:0] insn_out_w;
  logic [31:0] pc_out_w;

  int n_checks;
  int n_fail;

  fetch_prefetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'd0)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .address_imem   (address_imem),
    .q_imem         (q_imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .decode_ready   (decode_ready),
    .insn_valid     (insn_valid),
    .insn_out       (insn_out),
    .pc_out         (pc_out)
  );

  fetch_prefetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'hFFFF_FFFE)
  ) u_wrap (
    .clock          (clock),
    .reset          (reset),
    .address_imem   (address_imem_w),
    .q_imem         (q_imem_w),
    .redirect_valid (redirect_valid_w),
    .redirect_pc    (redirect_pc_w),
    .decode_ready   (decode_ready_w),
    .insn_valid     (insn_valid_w),
    .insn_out       (insn_out_w),
    .pc_out         (pc_out_w)
  );

  function automatic logic [31:0] imem(input logic [31:0] addr);
    return 32'h1000_0000 + addr;
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) q_imem   <= imem(address_imem);
  always @(posedge clock) q_imem_w <= imem(address_imem_w);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    decode_ready   = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    decode_ready     = 1'b1;
    redirect_valid_w = 1'b0;
    redirect_pc_w    = 32'h0;
    decode_ready_w   = 1'b1;

    // Reset state and free-running fetch, with the wrapping instance alongside
    step();
    step();
    check_eq("rst_valid", {31'b0, insn_valid}, 32'd0);
    check_eq("rst_insn", insn_out, 32'h0);
    check_eq("rst_pc", pc_out, 32'h0);
    check_eq("rst_addr", address_imem, 32'h0);
    check_eq("rst_addr_w", address_imem_w, 32'hFFFF_FFFE);
    reset = 1'b0;
    check_eq("c0_addr", address_imem, 32'd0);
    check_eq("c0_valid", {31'b0, insn_valid}, 32'd0);
    check_eq("c0_addr_w", address_imem_w, 32'hFFFF_FFFE);
    step();
    check_eq("c1_addr", address_imem, 32'd1);
    check_eq("c1_valid", {31'b0, insn_valid}, 32'd0);
    check_eq("c1_addr_w", address_imem_w, 32'hFFFF_FFFF);
    step();
    check_eq("c2_addr_w", address_imem_w, 32'h0);
    check_eq("c2_valid_w", {31'b0, insn_valid_w}, 32'd1);
    check_eq("c2_insn_w", insn_out_w, 32'h0FFF_FFFE);
    check_eq("c2_pc_w", pc_out_w, 32'hFFFF_FFFF);
    for (int k = 0; k < 6; k++) begin
      check_eq("run_valid", {31'b0, insn_valid}, 32'd1);
      check_eq("run_insn", insn_out, 32'h1000_0000 + k);
      check_eq("run_pc", pc_out, k + 1);
      check_eq("run_addr", address_imem, k + 2);
      if (k == 1) begin
        check_eq("c3_addr_w", address_imem_w, 32'h1);
        check_eq("c3_pc_w", pc_out_w, 32'h0);
      end
      if (k == 2) begin
        check_eq("c4_insn_w", insn_out_w, 32'h1000_0000);
        check_eq("c4_pc_w", pc_out_w, 32'h1);
      end
      step();
    end

    // Decode stall fills the queue and freezes fetch; release drains in order
    do_reset();
    step();
    step();
    check_eq("st_c2_insn", insn_out, 32'h1000_0000);
    step();
    decode_ready = 1'b0;
    repeat (9) step();
    check_eq("st_addr", address_imem, 32'd5);
    check_eq("st_valid", {31'b0, insn_valid}, 32'd1);
    check_eq("st_insn", insn_out, 32'h1000_0001);
    step();
    check_eq("st_addr_hold", address_imem, 32'd5);
    decode_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      check_eq("drain_valid", {31'b0, insn_valid}, 32'd1);
      check_eq("drain_insn", insn_out, 32'h1000_0000 + k);
      check_eq("drain_pc", pc_out, k + 1);
      step();
    end

    // Redirect with three queued entries, a pending request and a same-cycle dequeue
    do_reset();
    decode_ready = 1'b0;
    repeat (4) step();
    check_eq("rd_pre_insn", insn_out, 32'h1000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd100;
    decode_ready   = 1'b1;
    step();
    redirect_valid = 1'b0;
    check_eq("rd_c1_valid", {31'b0, insn_valid}, 32'd0);
    check_eq("rd_c1_addr", address_imem, 32'd100);
    step();
    check_eq("rd_c2_valid", {31'b0, insn_valid}, 32'd0);
    check_eq("rd_c2_insn", insn_out, 32'h0);
    check_eq("rd_c2_pc", pc_out, 32'h0);
    step();
    check_eq("rd_c3_valid", {31'b0, insn_valid}, 32'd1);
    check_eq("rd_c3_insn", insn_out, 32'h1000_0064);
    check_eq("rd_c3_pc", pc_out, 32'd101);
    step();
    check_eq("rd_c4_insn", insn_out, 32'h1000_0065);
    check_eq("rd_c4_pc", pc_out, 32'd102);

    // Back-to-back redirects: the second target wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'd40;
    step();
    check_eq("bb_addr40", address_imem, 32'd40);
    check_eq("bb_c1_valid", {31'b0, insn_valid}, 32'd0);
    redirect_pc = 32'd80;
    step();
    redirect_valid = 1'b0;
    check_eq("bb_addr80", address_imem, 32'd80);
    check_eq("bb_c2_valid", {31'b0, insn_valid}, 32'd0);
    step();
    check_eq("bb_c3_valid", {31'b0, insn_valid}, 32'd0);
    step();
    check_eq("bb_c4_valid", {31'b0, insn_valid}, 32'd1);
    check_eq("bb_c4_insn", insn_out, 32'h1000_0050);
    check_eq("bb_c4_pc", pc_out, 32'd81);

    // Asynchronous reset with a full queue takes effect before the next edge
    do_reset();
    decode_ready = 1'b0;
    repeat (6) step();
    check_eq("ar_pre_valid", {31'b0, insn_valid}, 32'd1);
    check_eq("ar_pre_insn", insn_out, 32'h1000_0000);
    check_eq("ar_pre_addr", address_imem, 32'd4);
    #3;
    reset = 1'b1;
    #1;
    check_eq("ar_valid", {31'b0, insn_valid}, 32'd0);
    check_eq("ar_insn", insn_out, 32'h0);
    check_eq("ar_pc", pc_out, 32'h0);
    check_eq("ar_addr", address_imem, 32'h0);
    step();
    reset        = 1'b0;
    decode_ready = 1'b1;
    check_eq("ar_c0_addr", address_imem, 32'd0);
    check_eq("ar_c0_valid", {31'b0, insn_valid}, 32'd0);
    step();
    check_eq("ar_c1_valid", {31'b0, insn_valid}, 32'd0);
    step();
    check_eq("ar_c2_valid", {31'b0, insn_valid}, 32'd1);
    check_eq("ar_c2_insn", insn_out, 32'h1000_0000);
    check_eq("ar_c2_pc", pc_out, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction fetch front end of the 5-stage pipelined CPU. Sits between the synchronous-read instruction memory and the decode stage latch.
- Owns the PC and keeps one imem request in flight each cycle.
- Buffers returned instructions in a small queue so that decode stalls do not drop fetches.
- Applies branch/jump redirects from execute by flushing all younger work.

Parameters:
- DEPTH, 4, number of prefetch queue entries; legal range 2..16.
- RESET_PC, 32'd0, value loaded into the PC on reset.

Ports:
- clock  input  1  master clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- address_imem  output  32  registered fetch PC presented to imem.
- q_imem  input  32  imem read data; valid one cycle after its address.
- redirect_valid  input  1  execute resolved a taken branch, jump, jal, jr or bex.
- redirect_pc  input  32  target PC, valid when redirect_valid is high.
- decode_ready  input  1  decode accepts the head entry this cycle.
- insn_valid  output  1  head entry holds a valid instruction.
- insn_out  output  32  head instruction; 32'h0 (nop) when insn_valid is low.
- pc_out  output  32  PC+1 of the head instruction; 32'h0 when insn_valid is low.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC, so address_imem = RESET_PC.
  - Queue empty, pend_valid = 0.
  - insn_valid = 0, insn_out = 0, pc_out = 0.
- Reset asserted mid-operation discards everything, including the in-flight request.
- State:
  - fetch_pc (32 bits).
  - pend_valid plus pend_pc: the request issued last cycle.
  - Circular queue of {insn, pc+1} with head, tail and count; count is clog2(DEPTH+1) bits.
- Issue rule: issue = !redirect_valid && (count + pend_valid < DEPTH).
- On an issue edge:
  - pend_valid <= 1, pend_pc <= fetch_pc.
  - fetch_pc <= fetch_pc + 1; wraps 32'hFFFFFFFF -> 0.
- When not issuing: pend_valid <= 0 and fetch_pc holds. address_imem still equals fetch_pc; the data returned for it is ignored.
- Response: if pend_valid and no redirect, then at the edge {q_imem, pend_pc+1} is written at tail and count increments.
- Dequeue: deq = insn_valid && decode_ready. Head advances and count decrements.
  - A simultaneous enqueue and dequeue leaves count unchanged.
- insn_valid = (count != 0). There is no bypass: a response becomes visible one cycle after its write edge.
- Latency: first instruction after reset is at address_imem in cycle 0 and on insn_valid in cycle 2.
  - Steady state delivers one instruction per cycle while decode_ready stays high.
- Full: count == DEPTH forces no write. The issue rule guarantees this, since count + pend_valid never exceeds DEPTH.
  - Full with deq in the same cycle: the head leaves and no write occurs.
- Redirect has absolute priority. At the edge where redirect_valid = 1:
  - Queue flushed: head = tail = count = 0.
  - pend_valid <= 0; the in-flight response is killed.
  - fetch_pc <= redirect_pc.
  - A simultaneous dequeue is treated as consumed; it is flushed anyway.
- After a redirect edge:
  - insn_valid = 0 in the following two cycles.
  - The target instruction is at the head, pc_out = redirect_pc + 1, in cycle +2.
- Back-to-back redirects: the last one wins, and each one restarts the 2-cycle refill.
- decode_ready low with an empty queue: no effect.

Decomposition:
- Shared package cpu_fetch_pkg holds:
  - NOP_INSN = 32'h0.
  - Default RESET_PC.
  - The queue entry typedef {insn[31:0], pc_next[31:0]}.
- One sub-module, fetch_queue: DEPTH-entry circular FIFO.
  - Ports: wr_en, wr_data, rd_en, flush, rd_data, count.
  - flush dominates wr_en and rd_en.
- PC, issue and pend logic stay in the top level.

Test Plan:
- Reset then decode_ready = 1, imem[k] = 32'h1000_0000+k → address_imem = 0,1,2,...; insn_valid rises in cycle 2 with insn_out = 32'h1000_0000, pc_out = 1; one instruction per cycle thereafter.
- decode_ready = 0 from cycle 2 for 10 cycles → count saturates at 4 and address_imem freezes at 5. Release → instructions 0..7 come out in order with no gaps or duplicates.
- Redirect with redirect_pc = 32'd100 while the queue holds 3 entries and a request is pending → insn_valid = 0 for 2 cycles, then insn_out = imem[100] with pc_out = 101; no stale entries appear.
- Redirect asserted on two consecutive cycles, to 40 then 80 → first valid output is imem[80].
- RESET_PC = 32'hFFFF_FFFE, free-running → fetch addresses FFFF_FFFE, FFFF_FFFF, 0, 1; the third delivered instruction has pc_out = 1.
- Assert reset asynchronously mid-stream with the queue full → outputs go to their reset values before the next edge; after release, fetch restarts at RESET_PC.
